// File: rtl/bure_stage_mem.sv
// Memory-access stage: runs RV32I loads/stores on a req/gnt/rvalid bus and
// hands aligned, extended results (or ALU pass-through) to writeback.
module bure_stage_mem #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_ex_valid,
    output logic                      o_ex_ready,
    input  logic [DATA_WIDTH-1:0]     i_ex_alu_data,
    input  logic [DATA_WIDTH-1:0]     i_ex_rs2_data,
    input  logic [2:0]                i_ex_funct3,
    input  logic                      i_ex_is_load,
    input  logic                      i_ex_is_store,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd_addr,
    input  logic                      i_ex_rd_we,
    output logic                      o_dmem_req,
    input  logic                      i_dmem_gnt,
    output logic                      o_dmem_we,
    output logic [ADDR_WIDTH-1:0]     o_dmem_addr,
    output logic [3:0]                o_dmem_be,
    output logic [DATA_WIDTH-1:0]     o_dmem_wdata,
    input  logic                      i_dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]     i_dmem_rdata,
    input  logic                      i_dmem_err,
    output logic                      o_mem_valid,
    output logic [REG_ADDR_WIDTH-1:0] o_mem_rd_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_rd_data,
    output logic                      o_mem_rd_we,
    output logic                      o_mem_fault
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                      state_q, state_d;
    logic                        req_q, req_d;
    logic                        we_q, we_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [3:0]                  be_q, be_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [1:0]                  lane_q, lane_d;
    logic [2:0]                  funct3_q, funct3_d;
    logic                        is_load_q, is_load_d;
    logic [REG_ADDR_WIDTH-1:0]   cap_rd_addr_q, cap_rd_addr_d;
    logic                        cap_rd_we_q, cap_rd_we_d;
    logic                        valid_q, valid_d;
    logic [REG_ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]       rd_data_q, rd_data_d;
    logic                        rd_we_q, rd_we_d;
    logic                        fault_q, fault_d;

    logic                        accept;
    logic                        is_mem;
    logic                        legal;
    logic                        misaligned;
    logic [1:0]                  size;
    logic [1:0]                  lane_in;
    logic [3:0]                  be_in;
    logic [DATA_WIDTH-1:0]       wdata_in;
    logic [DATA_WIDTH-1:0]       rshift;
    logic [DATA_WIDTH-1:0]       load_data;

    assign o_ex_ready = (state_q == S_IDLE);
    assign accept     = i_ex_valid & o_ex_ready;
    assign is_mem     = i_ex_is_load | i_ex_is_store;
    assign size       = i_ex_funct3[1:0];
    assign lane_in    = i_ex_alu_data[1:0];

    // Decode legality, alignment, byte lanes and replicated store data
    always_comb begin
        legal = 1'b0;
        if (i_ex_is_load && !i_ex_is_store) begin
            legal = (i_ex_funct3 == 3'd0) || (i_ex_funct3 == 3'd1) || (i_ex_funct3 == 3'd2) ||
                    (i_ex_funct3 == 3'd4) || (i_ex_funct3 == 3'd5);
        end else if (i_ex_is_store && !i_ex_is_load) begin
            legal = (i_ex_funct3 == 3'd0) || (i_ex_funct3 == 3'd1) || (i_ex_funct3 == 3'd2);
        end
        misaligned = ((size == 2'd1) && lane_in[0]) || ((size == 2'd2) && (lane_in != 2'd0));
        case (size)
            2'd0:    be_in = 4'b0001 << lane_in;
            2'd1:    be_in = 4'b0011 << lane_in;
            default: be_in = 4'b1111;
        endcase
        case (size)
            2'd0:    wdata_in = {4{i_ex_rs2_data[7:0]}};
            2'd1:    wdata_in = {2{i_ex_rs2_data[15:0]}};
            default: wdata_in = i_ex_rs2_data;
        endcase
        if (!i_ex_is_store) begin
            wdata_in = '0;
        end
    end

    // Lane select and sign/zero extension of the load response
    always_comb begin
        rshift = i_dmem_rdata >> {lane_q, 3'b000};
        case (funct3_q)
            3'd0:    load_data = {{24{rshift[7]}}, rshift[7:0]};
            3'd1:    load_data = {{16{rshift[15]}}, rshift[15:0]};
            3'd4:    load_data = {24'd0, rshift[7:0]};
            3'd5:    load_data = {16'd0, rshift[15:0]};
            default: load_data = i_dmem_rdata;
        endcase
    end

    // Next-state and register updates
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        lane_d        = lane_q;
        funct3_d      = funct3_q;
        is_load_d     = is_load_q;
        cap_rd_addr_d = cap_rd_addr_q;
        cap_rd_we_d   = cap_rd_we_q;
        valid_d       = 1'b0;
        rd_addr_d     = rd_addr_q;
        rd_data_d     = rd_data_q;
        rd_we_d       = rd_we_q;
        fault_d       = fault_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        valid_d   = 1'b1;
                        rd_addr_d = i_ex_rd_addr;
                        rd_data_d = i_ex_alu_data;
                        rd_we_d   = i_ex_rd_we;
                        fault_d   = 1'b0;
                    end else if (!legal || misaligned) begin
                        valid_d   = 1'b1;
                        rd_addr_d = i_ex_rd_addr;
                        rd_data_d = '0;
                        rd_we_d   = 1'b0;
                        fault_d   = 1'b1;
                    end else begin
                        state_d       = S_REQ;
                        req_d         = 1'b1;
                        we_d          = i_ex_is_store;
                        addr_d        = ADDR_WIDTH'(i_ex_alu_data) & ~ADDR_WIDTH'(3);
                        be_d          = be_in;
                        wdata_d       = wdata_in;
                        lane_d        = lane_in;
                        funct3_d      = i_ex_funct3;
                        is_load_d     = i_ex_is_load;
                        cap_rd_addr_d = i_ex_rd_addr;
                        cap_rd_we_d   = i_ex_rd_we;
                    end
                end
            end
            S_REQ: begin
                if (i_dmem_gnt) begin
                    state_d = S_WAIT;
                    req_d   = 1'b0;
                end
            end
            S_WAIT: begin
                if (i_dmem_rvalid) begin
                    state_d   = S_IDLE;
                    valid_d   = 1'b1;
                    rd_addr_d = cap_rd_addr_q;
                    fault_d   = i_dmem_err;
                    if (is_load_q) begin
                        rd_data_d = load_data;
                        rd_we_d   = cap_rd_we_q & ~i_dmem_err;
                    end else begin
                        rd_data_d = '0;
                        rd_we_d   = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q       <= S_IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            lane_q        <= '0;
            funct3_q      <= '0;
            is_load_q     <= 1'b0;
            cap_rd_addr_q <= '0;
            cap_rd_we_q   <= 1'b0;
            valid_q       <= 1'b0;
            rd_addr_q     <= '0;
            rd_data_q     <= '0;
            rd_we_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            lane_q        <= lane_d;
            funct3_q      <= funct3_d;
            is_load_q     <= is_load_d;
            cap_rd_addr_q <= cap_rd_addr_d;
            cap_rd_we_q   <= cap_rd_we_d;
            valid_q       <= valid_d;
            rd_addr_q     <= rd_addr_d;
            rd_data_q     <= rd_data_d;
            rd_we_q       <= rd_we_d;
            fault_q       <= fault_d;
        end
    end

    assign o_dmem_req    = req_q;
    assign o_dmem_we     = we_q;
    assign o_dmem_addr   = addr_q;
    assign o_dmem_be     = be_q;
    assign o_dmem_wdata  = wdata_q;
    assign o_mem_valid   = valid_q;
    assign o_mem_rd_addr = rd_addr_q;
    assign o_mem_rd_data = rd_data_q;
    assign o_mem_rd_we   = rd_we_q;
    assign o_mem_fault   = fault_q;

endmodule

// File: tb/tb_bure_stage_mem.sv
// Directed bench for bure_stage_mem with hand-computed expected values.
module tb_bure_stage_mem;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_ex_valid;
    logic        o_ex_ready;
    logic [31:0] i_ex_alu_data;
    logic [31:0] i_ex_rs2_data;
    logic [2:0]  i_ex_funct3;
    logic        i_ex_is_load;
    logic        i_ex_is_store;
    logic [4:0]  i_ex_rd_addr;
    logic        i_ex_rd_we;
    logic        o_dmem_req;
    logic        i_dmem_gnt;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        i_dmem_err;
    logic        o_mem_valid;
    logic [4:0]  o_mem_rd_addr;
    logic [31:0] o_mem_rd_data;
    logic        o_mem_rd_we;
    logic        o_mem_fault;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    bure_stage_mem dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready),
        .i_ex_alu_data(i_ex_alu_data), .i_ex_rs2_data(i_ex_rs2_data),
        .i_ex_funct3(i_ex_funct3), .i_ex_is_load(i_ex_is_load),
        .i_ex_is_store(i_ex_is_store), .i_ex_rd_addr(i_ex_rd_addr),
        .i_ex_rd_we(i_ex_rd_we),
        .o_dmem_req(o_dmem_req), .i_dmem_gnt(i_dmem_gnt), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata), .i_dmem_err(i_dmem_err),
        .o_mem_valid(o_mem_valid), .o_mem_rd_addr(o_mem_rd_addr),
        .o_mem_rd_data(o_mem_rd_data), .o_mem_rd_we(o_mem_rd_we), .o_mem_fault(o_mem_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present one execute result for exactly one accepting edge
    task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                         input logic ld, input logic st, input logic [4:0] rd, input logic we);
        i_ex_valid    = 1'b1;
        i_ex_alu_data = alu;
        i_ex_rs2_data = rs2;
        i_ex_funct3   = f3;
        i_ex_is_load  = ld;
        i_ex_is_store = st;
        i_ex_rd_addr  = rd;
        i_ex_rd_we    = we;
        step();
        i_ex_valid    = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = data;
        i_dmem_err    = err;
        step();
        i_dmem_rvalid = 1'b0;
        i_dmem_err    = 1'b0;
    endtask

    initial begin
        i_rstn = 1'b0;
        i_ex_valid = 1'b0; i_ex_alu_data = '0; i_ex_rs2_data = '0; i_ex_funct3 = '0;
        i_ex_is_load = 1'b0; i_ex_is_store = 1'b0; i_ex_rd_addr = '0; i_ex_rd_we = 1'b0;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0; i_dmem_err = 1'b0;
        #12;
        chk("rst_ready", 32'(o_ex_ready), 32'd1);
        chk("rst_valid", 32'(o_mem_valid), 32'd0);
        chk("rst_req",   32'(o_dmem_req), 32'd0);
        chk("rst_be",    32'(o_dmem_be), 32'd0);
        chk("rst_addr",  o_dmem_addr, 32'd0);
        i_rstn = 1'b1;
        step();

        // ALU pass-through
        issue(32'h1234, 32'h0, 3'd0, 1'b0, 1'b0, 5'd5, 1'b1);
        chk("pt_valid", 32'(o_mem_valid), 32'd1);
        chk("pt_data",  o_mem_rd_data, 32'h0000_1234);
        chk("pt_we",    32'(o_mem_rd_we), 32'd1);
        chk("pt_rd",    32'(o_mem_rd_addr), 32'd5);
        chk("pt_fault", 32'(o_mem_fault), 32'd0);
        chk("pt_ready", 32'(o_ex_ready), 32'd1);
        chk("pt_noreq", 32'(o_dmem_req), 32'd0);
        step();
        chk("pt_pulse", 32'(o_mem_valid), 32'd0);

        // LB at 0x103, immediate grant, response one cycle later
        issue(32'h103, 32'h0, 3'd0, 1'b1, 1'b0, 5'd7, 1'b1);
        chk("lb_ready", 32'(o_ex_ready), 32'd0);
        chk("lb_req",   32'(o_dmem_req), 32'd1);
        chk("lb_addr",  o_dmem_addr, 32'h100);
        chk("lb_be",    32'(o_dmem_be), 32'h8);
        chk("lb_we",    32'(o_dmem_we), 32'd0);
        chk("lb_wdata", o_dmem_wdata, 32'd0);
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        chk("lb_req_drop", 32'(o_dmem_req), 32'd0);
        chk("lb_wait_rdy", 32'(o_ex_ready), 32'd0);
        chk("lb_wait_vld", 32'(o_mem_valid), 32'd0);
        respond(32'h80FF_FF00, 1'b0);
        chk("lb_valid", 32'(o_mem_valid), 32'd1);
        chk("lb_data",  o_mem_rd_data, 32'hFFFF_FF80);
        chk("lb_rdwe",  32'(o_mem_rd_we), 32'd1);
        chk("lb_rd",    32'(o_mem_rd_addr), 32'd7);
        chk("lb_fault", 32'(o_mem_fault), 32'd0);
        chk("lb_ready_back", 32'(o_ex_ready), 32'd1);
        step();

        // SH at 0x202 with a grant delayed by three cycles
        issue(32'h202, 32'hAAAA_BEEF, 3'd1, 1'b0, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("sh_req",   32'(o_dmem_req), 32'd1);
            chk("sh_addr",  o_dmem_addr, 32'h200);
            chk("sh_be",    32'(o_dmem_be), 32'hC);
            chk("sh_wdata", o_dmem_wdata, 32'hBEEF_BEEF);
            chk("sh_we",    32'(o_dmem_we), 32'd1);
            step();
        end
        i_dmem_gnt = 1'b1;
        chk("sh_req_at_gnt", 32'(o_dmem_req), 32'd1);
        step();
        i_dmem_gnt = 1'b0;
        chk("sh_req_drop", 32'(o_dmem_req), 32'd0);
        step();
        chk("sh_no_early", 32'(o_mem_valid), 32'd0);
        respond(32'h0, 1'b0);
        chk("sh_valid", 32'(o_mem_valid), 32'd1);
        chk("sh_rdwe",  32'(o_mem_rd_we), 32'd0);
        chk("sh_data",  o_mem_rd_data, 32'd0);
        chk("sh_fault", 32'(o_mem_fault), 32'd0);
        step();

        // SB at 0x301: single-lane enable, replicated byte
        issue(32'h301, 32'h1234_5655, 3'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        chk("sb_be",    32'(o_dmem_be), 32'h2);
        chk("sb_wdata", o_dmem_wdata, 32'h5555_5555);
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        respond(32'h0, 1'b0);
        chk("sb_valid", 32'(o_mem_valid), 32'd1);
        step();

        // Misaligned LW at 0x6
        issue(32'h6, 32'h0, 3'd2, 1'b1, 1'b0, 5'd9, 1'b1);
        chk("mis_req",   32'(o_dmem_req), 32'd0);
        chk("mis_valid", 32'(o_mem_valid), 32'd1);
        chk("mis_fault", 32'(o_mem_fault), 32'd1);
        chk("mis_rdwe",  32'(o_mem_rd_we), 32'd0);
        chk("mis_ready", 32'(o_ex_ready), 32'd1);

        // Illegal store funct3=4, then load+store together
        issue(32'h40, 32'h0, 3'd4, 1'b0, 1'b1, 5'd0, 1'b0);
        chk("ill_st_req",   32'(o_dmem_req), 32'd0);
        chk("ill_st_fault", 32'(o_mem_fault), 32'd1);
        issue(32'h40, 32'h0, 3'd2, 1'b1, 1'b1, 5'd1, 1'b1);
        chk("ill_ls_req",   32'(o_dmem_req), 32'd0);
        chk("ill_ls_valid", 32'(o_mem_valid), 32'd1);
        chk("ill_ls_fault", 32'(o_mem_fault), 32'd1);
        step();

        // LHU at 0x10 answered with a bus error
        issue(32'h10, 32'h0, 3'd5, 1'b1, 1'b0, 5'd3, 1'b1);
        chk("err_req", 32'(o_dmem_req), 32'd1);
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        respond(32'h0000_ABCD, 1'b1);
        chk("err_valid", 32'(o_mem_valid), 32'd1);
        chk("err_fault", 32'(o_mem_fault), 32'd1);
        chk("err_rdwe",  32'(o_mem_rd_we), 32'd0);
        step();

        // Reset while waiting for the response
        issue(32'h20, 32'h0, 3'd2, 1'b1, 1'b0, 5'd4, 1'b1);
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        i_rstn = 1'b0;
        #1;
        chk("mrst_req",   32'(o_dmem_req), 32'd0);
        chk("mrst_ready", 32'(o_ex_ready), 32'd1);
        chk("mrst_valid", 32'(o_mem_valid), 32'd0);
        chk("mrst_fault", 32'(o_mem_fault), 32'd0);
        i_rstn = 1'b1;
        step();
        respond(32'hDEAD_BEEF, 1'b0);
        chk("mrst_stale", 32'(o_mem_valid), 32'd0);

        // Normal LW after reset, then a back-to-back pass-through in the valid cycle
        issue(32'h24, 32'h0, 3'd2, 1'b1, 1'b0, 5'd6, 1'b1);
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        respond(32'h1234_5678, 1'b0);
        chk("lw_valid", 32'(o_mem_valid), 32'd1);
        chk("lw_data",  o_mem_rd_data, 32'h1234_5678);
        chk("lw_rd",    32'(o_mem_rd_addr), 32'd6);
        issue(32'hCAFE, 32'h0, 3'd0, 1'b0, 1'b0, 5'd8, 1'b1);
        chk("b2b_valid", 32'(o_mem_valid), 32'd1);
        chk("b2b_data",  o_mem_rd_data, 32'h0000_CAFE);
        chk("b2b_rd",    32'(o_mem_rd_addr), 32'd8);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
